imem_fetch_sync: RTL and testbench

Parametrised, synchronous instruction memory for the pipelined RISC-V core's IF stage. Returns one 32-bit little-endian instruction per fetch with one-cycle registered latency. Supports pipeline stall and flush, raises a sticky fault on misaligned or out-of-range fetches, and accepts word writes from a program-load port during operation.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/imem_array.sv | 32 +++
 rtl/imem_fetch_sync.sv | 122 ++++++++++++
 tb/tb_imem_fetch_sync.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: canonical NOP encoding and the
// instruction-fetch FSM state type.
package riscv_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// Word-wide instruction storage: one synchronous read port and one synchronous
// write port, read-before-write on a same-address collision.
module imem_array #(
    parameter  int DEPTH_WORDS = 128,
    localparam int IW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [IW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Write port; contents are deliberately left unreset so the array maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port; the output register holds while rd_en is low, which implements IF stall.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/imem_fetch_sync.sv
// IF-stage instruction memory: one-cycle registered fetch with stall/flush,
// sticky misaligned/out-of-range fault, and a program-load write port.
module imem_fetch_sync
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        stall,
    input  logic        flush,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic        fetch_fault
);

    localparam int AW = $clog2(DEPTH_WORDS) + 2;

    imem_state_t state_r, state_s;
    logic        valid_r, valid_s;
    logic        fault_r, fault_s;
    logic [31:0] pc_r, pc_s;
    logic        rd_en_s;
    logic        wr_en_s;
    logic [31:0] rd_data_s;
    logic [1:0]  unused_load_lsb_s;

    function automatic logic addr_in_range(input logic [31:0] addr);
        return ~|addr[31:AW];
    endfunction

    function automatic logic fetch_legal(input logic [31:0] addr);
        return addr_in_range(addr) && (addr[1:0] == 2'b00);
    endfunction

    assign unused_load_lsb_s = load_addr[1:0];
    assign wr_en_s           = load_en && addr_in_range(load_addr);

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .rd_en   (rd_en_s),
        .rd_addr (fetch_addr[AW-1:2]),
        .rd_data (rd_data_s),
        .wr_en   (wr_en_s),
        .wr_addr (load_addr[AW-1:2]),
        .wr_data (load_data)
    );

    // Next-state and RAM read-enable: flush beats stall beats fetch_req.
    always_comb begin
        state_s = state_r;
        valid_s = valid_r;
        fault_s = fault_r;
        pc_s    = pc_r;
        rd_en_s = 1'b0;
        if (rst) begin
            rd_en_s = 1'b0;
        end else if (flush) begin
            state_s = RUN;
            valid_s = 1'b0;
            fault_s = 1'b0;
        end else if (stall) begin
            rd_en_s = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (fetch_req) begin
                        pc_s = fetch_addr;
                        if (fetch_legal(fetch_addr)) begin
                            valid_s = 1'b1;
                            rd_en_s = 1'b1;
                        end else begin
                            valid_s = 1'b0;
                            fault_s = 1'b1;
                            state_s = FAULT;
                        end
                    end else begin
                        valid_s = 1'b0;
                    end
                end
                FAULT: begin
                    state_s = FAULT;
                end
                default: begin
                    state_s = RUN;
                    valid_s = 1'b0;
                    fault_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            valid_r <= 1'b0;
            fault_r <= 1'b0;
            pc_r    <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            valid_r <= valid_s;
            fault_r <= fault_s;
            pc_r    <= pc_s;
        end
    end

    // The RAM output register is the instruction register; invalid slots read as NOP.
    assign instr_out   = valid_r ? rd_data_s : RV_NOP;
    assign instr_valid = valid_r;
    assign pc_out      = pc_r;
    assign fetch_fault = fault_r;

endmodule

// File: tb/tb_imem_fetch_sync.sv
// Scoreboard bench for imem_fetch_sync: directed per-cycle vectors push the
// expected registered outputs; a negedge monitor pops and compares.
module tb_imem_fetch_sync;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        stall;
    logic        flush;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        fetch_fault;

    typedef struct {
        int          due;
        string       name;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    imem_fetch_sync #(.DEPTH_WORDS(128)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .stall       (stall),
        .flush       (flush),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare the registered outputs in the cycle each expectation falls due.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            checks = checks + 1;
            if (instr_out !== e.instr || instr_valid !== e.valid ||
                pc_out !== e.pc || fetch_fault !== e.fault) begin
                failures = failures + 1;
                $display("FAIL %s: got instr=%08h valid=%b pc=%08h fault=%b, want instr=%08h valid=%b pc=%08h fault=%b",
                         e.name, instr_out, instr_valid, pc_out, fetch_fault,
                         e.instr, e.valid, e.pc, e.fault);
            end
        end
    end

    // One clock of stimulus plus the outputs expected after the coming edge.
    task automatic step(input string name, input logic r, input logic req,
                        input logic [31:0] fa, input logic st, input logic fl,
                        input logic ld, input logic [31:0] la, input logic [31:0] ldat,
                        input logic [31:0] e_instr, input logic e_valid,
                        input logic [31:0] e_pc, input logic e_fault);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = r;
        fetch_req  = req;
        fetch_addr = fa;
        stall      = st;
        flush      = fl;
        load_en    = ld;
        load_addr  = la;
        load_data  = ldat;
        e.due   = cyc + 1;
        e.name  = name;
        e.instr = e_instr;
        e.valid = e_valid;
        e.pc    = e_pc;
        e.fault = e_fault;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = 32'h0; stall = 1'b0; flush = 1'b0;
        load_en = 1'b0; load_addr = 32'h0; load_data = 32'h0;

        //    name          rst   req   faddr          stall flush ld   laddr          ldata          instr          v     pc             fault
        step("reset",       1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'h0000_0000, 1'b0);
        step("load0",       1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0050_0093, NOP,           1'b0, 32'h0000_0000, 1'b0);
        step("load4",       1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h00A0_0113, NOP,           1'b0, 32'h0000_0000, 1'b0);
        step("load8",       1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, NOP,           1'b0, 32'h0000_0000, 1'b0);
        step("load1fc",     1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_01FC, 32'h2222_2222, NOP,           1'b0, 32'h0000_0000, 1'b0);
        step("fetch0",      1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0050_0093, 1'b1, 32'h0000_0000, 1'b0);
        step("fetch4",      1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h00A0_0113, 1'b1, 32'h0000_0004, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h00A0_0113, 1'b1, 32'h0000_0004, 1'b0);
        end
        step("idle",        1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'h0000_0004, 1'b0);
        step("misalign",    1'b0, 1'b1, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'h0000_0006, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step("fault_hold", 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'h0000_0006, 1'b1);
        end
        step("flush1",      1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'h0000_0006, 1'b0);
        step("post_flush",  1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0050_0093, 1'b1, 32'h0000_0000, 1'b0);
        step("range200",    1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'h0000_0200, 1'b1);
        step("flush2",      1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'h0000_0200, 1'b0);
        step("load200",     1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h3333_3333, NOP,           1'b0, 32'h0000_0200, 1'b0);
        step("fetch1fc",    1'b0, 1'b1, 32'h0000_01FC, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h2222_2222, 1'b1, 32'h0000_01FC, 1'b0);
        step("no_alias0",   1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0050_0093, 1'b1, 32'h0000_0000, 1'b0);
        step("rbw_old",     1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 32'h0000_0008, 1'b0);
        step("rbw_new",     1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 32'h0000_0008, 1'b0);
        step("flush_kill",  1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'h0000_0008, 1'b0);
        step("misalign2",   1'b0, 1'b1, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'h0000_0006, 1'b1);
        step("rst_fault",   1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'h0000_0000, 1'b0);
        step("post_rst",    1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0050_0093, 1'b1, 32'h0000_0000, 1'b0);
        step("range_hi",    1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'hFFFF_FFFC, 1'b1);
        step("reset2",      1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'h0000_0000, 1'b0);
        step("stall_load",  1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 32'h4444_4444, NOP,           1'b0, 32'h0000_0000, 1'b0);
        step("fetchC",      1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h4444_4444, 1'b1, 32'h0000_000C, 1'b0);
        step("flush_stall", 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, NOP,           1'b0, 32'h0000_000C, 1'b0);
        step("fetch_after", 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h00A0_0113, 1'b1, 32'h0000_0004, 1'b0);

        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks = checks + 1;
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
